matris_besleyici: RTL and testbench

//  Feeds the 2x4 by 4x2 matrix multiplier, sending it 16 operand words on one serial

---
 rtl/matris_besleyici_if.sv | 24 ++
 rtl/matris_besleyici.sv | 82 ++++++++
 tb/tb_matris_besleyici.sv | 138 +++++++++++++
 3 files changed

// File: rtl/matris_besleyici_if.sv
// matris_besleyici_if: operand load, start, operand stream and result bus of the multiplier feeder
interface matris_besleyici_if #(parameter int M = 8);
  localparam int R = 2*M+2;
  logic yaz_en;
  logic [3:0] yaz_adr;
  logic [M-1:0] yaz_veri;
  logic basla;
  logic [M-1:0] matris_veri;
  logic matris_gecerli;
  logic [R-1:0] carpim_veri;
  logic carpim_gecerli;
  logic [4*R-1:0] sonuc;
  logic mesgul;
  logic bitti;
  logic hata;
  modport master (
    output yaz_en, yaz_adr, yaz_veri, basla, carpim_veri, carpim_gecerli,
    input matris_veri, matris_gecerli, sonuc, mesgul, bitti, hata
  );
  modport slave (
    input yaz_en, yaz_adr, yaz_veri, basla, carpim_veri, carpim_gecerli,
    output matris_veri, matris_gecerli, sonuc, mesgul, bitti, hata
  );
endinterface

// File: rtl/matris_besleyici.sv
// matris_besleyici: streams 16 preloaded operands to the 2x4*4x2 multiplier and collects its 4 results
module matris_besleyici #(
  parameter int M = 8,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  matris_besleyici_if.slave bus
);
  localparam int R = 2*M+2;
  localparam int W = $clog2(TIMEOUT+1);
  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
  state_t state;
  logic [M-1:0] mem [16];
  logic [3:0] idx;
  logic [1:0] k;
  logic [W-1:0] w;
  logic [R-1:0] slot [0:2];
  logic [M-1:0] nxt;
  // word 0 is read in the start cycle, so a simultaneous write to it is forwarded
  always_comb nxt = (state == IDLE) ? ((bus.yaz_en && bus.yaz_adr == 4'd0) ? bus.yaz_veri : mem[0]) : mem[idx+4'd1];
  always_ff @(posedge clk)
    if (!rst && state == IDLE && bus.yaz_en) mem[bus.yaz_adr] <= bus.yaz_veri;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      k <= '0;
      w <= '0;
      for (int i = 0; i < 3; i++) slot[i] <= '0;
      bus.matris_veri <= '0;
      bus.matris_gecerli <= 1'b0;
      bus.sonuc <= '0;
      bus.mesgul <= 1'b0;
      bus.bitti <= 1'b0;
      bus.hata <= 1'b0;
    end else begin
      bus.bitti <= 1'b0;
      case (state)
        IDLE: if (bus.basla) begin
          state <= SEND;
          idx <= '0;
          bus.hata <= 1'b0;
          bus.mesgul <= 1'b1;
          bus.matris_gecerli <= 1'b1;
          bus.matris_veri <= nxt;
        end
        SEND: if (idx == 4'd15) begin
          state <= WAIT;
          w <= '0;
          k <= '0;
          bus.matris_gecerli <= 1'b0;
          bus.matris_veri <= '0;
        end else begin
          idx <= idx + 4'd1;
          bus.matris_veri <= nxt;
        end
        WAIT: begin
          w <= w + 1'b1;
          if (bus.carpim_gecerli && k == 2'd3) begin
            // fourth result goes straight into sonuc so bitti follows it by one cycle
            state <= DONE;
            bus.sonuc <= {bus.carpim_veri, slot[2], slot[1], slot[0]};
            bus.bitti <= 1'b1;
            bus.mesgul <= 1'b0;
          end else begin
            if (bus.carpim_gecerli) begin
              slot[k] <= bus.carpim_veri;
              k <= k + 2'd1;
            end
            if (w == W'(TIMEOUT-1)) begin
              state <= IDLE;
              bus.hata <= 1'b1;
              bus.mesgul <= 1'b0;
            end
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matris_besleyici.sv
// tb_matris_besleyici: timeline model of the feeder checked every cycle, plus literal result checks
module tb_matris_besleyici;
  localparam int M = 8;
  localparam int R = 2*M+2;
  localparam int TIMEOUT = 64;
  localparam int BIG = 1 << 30;
  logic clk = 0;
  logic rst = 1;
  matris_besleyici_if #(.M(M)) bus ();
  matris_besleyici #(.M(M), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int total = 0;
  int passed = 0;
  int c = 0;
  int run_t = -1;
  int end_c = -1;
  int done_c = -1;
  int nres = 0;
  logic [M-1:0] mdl_mem [16];
  logic [R-1:0] cap [4];
  logic e_hata = 0;
  logic [4*R-1:0] e_sonuc = '0;
  logic [4*R-1:0] lit1, lit2;
  task automatic chk(input string n, input logic [4*R-1:0] a, input logic [4*R-1:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h (model cycle %0d)", n, a, e, c);
  endtask
  function automatic logic [R-1:0] cval(input int j);
    int s = 0;
    for (int q = 0; q < 4; q++) s += int'(mdl_mem[4*(j/2)+q]) * int'(mdl_mem[8+2*q+(j%2)]);
    return R'(s);
  endfunction
  always @(negedge clk) begin
    bit send, wt, idle;
    c++;
    send = run_t >= 0 && c >= run_t+1 && c <= run_t+16;
    wt = run_t >= 0 && c >= run_t+17 && c < end_c;
    idle = !(send || wt || c == done_c);
    chk("gecerli", {71'b0, bus.matris_gecerli}, {71'b0, send});
    chk("veri", {64'b0, bus.matris_veri}, send ? {64'b0, mdl_mem[c-run_t-1]} : '0);
    chk("mesgul", {71'b0, bus.mesgul}, {71'b0, send || wt});
    chk("bitti", {71'b0, bus.bitti}, {71'b0, c == done_c});
    chk("hata", {71'b0, bus.hata}, {71'b0, e_hata});
    chk("sonuc", bus.sonuc, e_sonuc);
    if (rst) begin
      run_t = -1; end_c = -1; done_c = -1; nres = 0; e_hata = 0; e_sonuc = '0;
    end else begin
      if (idle && bus.yaz_en) mdl_mem[bus.yaz_adr] = bus.yaz_veri;
      if (idle && bus.basla) begin
        run_t = c; end_c = BIG; done_c = -1; nres = 0; e_hata = 0;
      end
      if (wt) begin
        if (bus.carpim_gecerli) begin
          cap[nres] = bus.carpim_veri;
          nres++;
        end
        if (nres == 4) begin
          done_c = c+1; end_c = c+1;
          e_sonuc = {cap[3], cap[2], cap[1], cap[0]};
        end else if (c == run_t+16+TIMEOUT) begin
          end_c = c+1; e_hata = 1;
        end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [M-1:0] a [16]);
    for (int i = 0; i < 16; i++) begin
      bus.yaz_en = 1; bus.yaz_adr = 4'(i); bus.yaz_veri = a[i];
      tick;
    end
    bus.yaz_en = 0;
  endtask
  task automatic run(input int n, input int gap, input bit noise);
    bus.basla = 1;
    tick;
    bus.basla = 0;
    for (int i = 0; i < 16; i++) begin
      if (noise && i == 6) begin
        bus.basla = 1; bus.yaz_en = 1; bus.yaz_adr = 4'd3; bus.yaz_veri = 8'd99;
        bus.carpim_gecerli = 1; bus.carpim_veri = 18'd12345;
      end
      tick;
      bus.basla = 0; bus.yaz_en = 0; bus.carpim_gecerli = 0;
    end
    for (int j = 0; j < n; j++) begin
      repeat (gap) tick;
      bus.carpim_gecerli = 1; bus.carpim_veri = cval(j);
      tick;
      bus.carpim_gecerli = 0;
    end
    if (n == 4) tick;
    else repeat (TIMEOUT+2) tick;
  endtask
  initial begin
    logic [M-1:0] a [16];
    bus.yaz_en = 0; bus.yaz_adr = 0; bus.yaz_veri = 0; bus.basla = 0;
    bus.carpim_gecerli = 0; bus.carpim_veri = 0;
    lit1 = {18'd140, 18'd114, 18'd60, 18'd50};
    lit2 = {4{18'h3F804}};
    repeat (3) tick;
    rst = 0;
    for (int i = 0; i < 16; i++) a[i] = M'(i % 8 + 1);
    load(a);
    run(4, 0, 0);
    chk("t1_sonuc", bus.sonuc, lit1);
    run(4, 2, 1);
    chk("t4_sonuc", bus.sonuc, lit1);
    run(3, 0, 0);
    chk("t3_hata", {71'b0, bus.hata}, 72'd1);
    chk("t3_sonuc", bus.sonuc, lit1);
    run(4, 3, 0);
    chk("t6_hata", {71'b0, bus.hata}, 72'd0);
    chk("t6_sonuc", bus.sonuc, lit1);
    bus.basla = 1;
    tick;
    bus.basla = 0;
    repeat (7) tick;
    rst = 1;
    tick;
    rst = 0;
    chk("t5_gecerli", {71'b0, bus.matris_gecerli}, 72'd0);
    chk("t5_mesgul", {71'b0, bus.mesgul}, 72'd0);
    run(4, 1, 0);
    chk("t5_sonuc", bus.sonuc, lit1);
    for (int i = 0; i < 16; i++) a[i] = 8'hFF;
    load(a);
    run(4, 1, 0);
    chk("t2_sonuc", bus.sonuc, lit2);
    repeat (3) tick;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
